// File: rtl/axi_ad9364_rx_pattern_chk_pkg.sv
// Shared definitions for the AD9364 receive pattern checker: FSM encodings and the
// default two-word loopback pattern that the DAC data generator also transmits.
package axi_ad9364_rx_pattern_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  localparam logic [11:0] DEF_PAT_I0 = 12'o2064;
  localparam logic [11:0] DEF_PAT_Q0 = 12'o1753;
  localparam logic [11:0] DEF_PAT_I1 = 12'o4402;
  localparam logic [11:0] DEF_PAT_Q1 = 12'o1337;

  function automatic logic [23:0] iq_word(input logic [11:0] i, input logic [11:0] q);
    return {i, q};
  endfunction

endpackage

// File: rtl/axi_ad9364_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module axi_ad9364_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_ad9364_rx_pattern_chk.sv
// Checks received I/Q words against the alternating two-word loopback pattern:
// stage 1 registers the adc bus, stage 2 compares and runs the lock FSM and counters.
module axi_ad9364_rx_pattern_chk
  import axi_ad9364_rx_pattern_chk_pkg::*;
#(
  parameter logic [11:0] PAT_I0     = DEF_PAT_I0,
  parameter logic [11:0] PAT_Q0     = DEF_PAT_Q0,
  parameter logic [11:0] PAT_I1     = DEF_PAT_I1,
  parameter logic [11:0] PAT_Q1     = DEF_PAT_Q1,
  parameter int          LOCK_COUNT = 16,
  parameter int          ERR_LIMIT  = 4,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 adc_valid,
  input  logic [11:0]          adc_data_i1,
  input  logic [11:0]          adc_data_q1,
  input  logic [11:0]          adc_data_i2,
  input  logic [11:0]          adc_data_q2,
  input  logic                 adc_r1_mode,
  input  logic                 chk_enable,
  input  logic                 chk_clear,
  output logic                 chk_locked,
  output logic                 chk_err,
  output logic                 chk_oos,
  output logic [CNT_WIDTH-1:0] chk_match_count,
  output logic [CNT_WIDTH-1:0] chk_err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int RW = $clog2(ERR_LIMIT + 1);
  localparam logic [23:0] P0 = {PAT_I0, PAT_Q0};
  localparam logic [23:0] P1 = {PAT_I1, PAT_Q1};

  logic        s1_vld;
  logic        s1_r1_mode;
  logic [11:0] s1_i1, s1_q1, s1_i2, s1_q2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld     <= 1'b0;
      s1_r1_mode <= 1'b0;
      s1_i1      <= '0;
      s1_q1      <= '0;
      s1_i2      <= '0;
      s1_q2      <= '0;
    end else begin
      s1_vld     <= adc_valid;
      s1_r1_mode <= adc_r1_mode;
      s1_i1      <= adc_data_i1;
      s1_q1      <= adc_data_q1;
      s1_i2      <= adc_data_i2;
      s1_q2      <= adc_data_q2;
    end
  end

  chk_state_t    state, state_nxt;
  logic          phase, phase_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [RW-1:0] err_run, run_nxt;
  logic          oos_nxt, err_nxt;
  logic          match_inc, err_inc;

  logic [23:0] smp1, smp2;
  logic        hit_p0, hit_p1, good, mode_chg;

  assign smp1     = iq_word(s1_i1, s1_q1);
  assign smp2     = iq_word(s1_i2, s1_q2);
  assign hit_p0   = (smp1 == P0);
  assign hit_p1   = (smp1 == P1);
  assign good     = s1_r1_mode ? (phase ? hit_p1 : hit_p0) : (hit_p0 && (smp2 == P1));
  // the mode change is seen on the edge where stage 1 picks up the new mode
  assign mode_chg = (adc_r1_mode != s1_r1_mode);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      good_cnt <= '0;
      err_run  <= '0;
      chk_oos  <= 1'b0;
      chk_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      good_cnt <= good_nxt;
      err_run  <= run_nxt;
      chk_oos  <= oos_nxt;
      chk_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    good_nxt  = good_cnt;
    run_nxt   = err_run;
    oos_nxt   = 1'b0;
    err_nxt   = chk_err;
    match_inc = 1'b0;
    err_inc   = 1'b0;
    if (!chk_enable) begin
      state_nxt = ST_IDLE;
      good_nxt  = '0;
      run_nxt   = '0;
    end else if (state == ST_IDLE) begin
      state_nxt = ST_SEARCH;
      good_nxt  = '0;
      run_nxt   = '0;
    end else if (mode_chg) begin
      state_nxt = ST_SEARCH;
      good_nxt  = '0;
      run_nxt   = '0;
    end else if (s1_vld) begin
      case (state)
        ST_SEARCH: begin
          if (s1_r1_mode) begin
            if (good) begin
              good_nxt  = good_cnt + GW'(1);
              phase_nxt = ~phase;
            end else if (hit_p0 || hit_p1) begin
              // re-seed: expect the other word next
              good_nxt  = GW'(1);
              phase_nxt = hit_p0;
            end else begin
              good_nxt  = '0;
            end
          end else begin
            good_nxt = good ? good_cnt + GW'(1) : '0;
          end
          if (good_nxt == GW'(LOCK_COUNT)) begin
            state_nxt = ST_LOCKED;
            run_nxt   = '0;
          end
        end
        ST_LOCKED: begin
          if (s1_r1_mode) phase_nxt = ~phase;
          if (good) begin
            match_inc = 1'b1;
            run_nxt   = '0;
          end else begin
            err_inc   = 1'b1;
            err_nxt   = 1'b1;
            run_nxt   = err_run + RW'(1);
          end
          if (run_nxt == RW'(ERR_LIMIT)) begin
            state_nxt = ST_SEARCH;
            good_nxt  = '0;
            run_nxt   = '0;
            oos_nxt   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (chk_clear) err_nxt = 1'b0;
  end

  assign chk_locked = (state == ST_LOCKED);

  axi_ad9364_sat_cnt #(.WIDTH(CNT_WIDTH)) u_match_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (chk_clear),
    .inc  (match_inc),
    .cnt  (chk_match_count)
  );

  axi_ad9364_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (chk_clear),
    .inc  (err_inc),
    .cnt  (chk_err_count)
  );

endmodule

// File: tb/tb_axi_ad9364_rx_pattern_chk.sv
// Directed plus randomized bench for axi_ad9364_rx_pattern_chk; a 32-bit and a 4-bit
// counter build see the same stimulus and are compared against a sample-level model.
module tb_axi_ad9364_rx_pattern_chk;

  localparam logic [23:0] P0 = {12'o2064, 12'o1753};
  localparam logic [23:0] P1 = {12'o4402, 12'o1337};
  localparam int LOCK = 16;
  localparam int LIM  = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        adc_valid;
  logic [11:0] adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2;
  logic        adc_r1_mode;
  logic        chk_enable;
  logic        chk_clear;

  logic        locked, err, oos;
  logic [31:0] match_cnt, err_cnt;
  logic        locked4, err4, oos4;
  logic [3:0]  match_cnt4, err_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_ad9364_rx_pattern_chk dut (
    .clk(clk), .rstn(rstn), .adc_valid(adc_valid),
    .adc_data_i1(adc_data_i1), .adc_data_q1(adc_data_q1),
    .adc_data_i2(adc_data_i2), .adc_data_q2(adc_data_q2),
    .adc_r1_mode(adc_r1_mode), .chk_enable(chk_enable), .chk_clear(chk_clear),
    .chk_locked(locked), .chk_err(err), .chk_oos(oos),
    .chk_match_count(match_cnt), .chk_err_count(err_cnt)
  );

  axi_ad9364_rx_pattern_chk #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .adc_valid(adc_valid),
    .adc_data_i1(adc_data_i1), .adc_data_q1(adc_data_q1),
    .adc_data_i2(adc_data_i2), .adc_data_q2(adc_data_q2),
    .adc_r1_mode(adc_r1_mode), .chk_enable(chk_enable), .chk_clear(chk_clear),
    .chk_locked(locked4), .chk_err(err4), .chk_oos(oos4),
    .chk_match_count(match_cnt4), .chk_err_count(err_cnt4)
  );

  // Reference model: 0 idle, 1 searching, 2 locked; want_p1 = which word is expected next.
  int     m_state;
  bit     m_want_p1;
  int     m_good, m_run;
  bit     m_err, m_oos;
  longint m_match, m_errc;
  bit     tx_p1;

  task automatic m_reset();
    m_state = 0; m_want_p1 = 0; m_good = 0; m_run = 0;
    m_err = 0; m_oos = 0; m_match = 0; m_errc = 0;
  endtask

  task automatic m_sample(input logic [23:0] a, input logic [23:0] b, input bit r1, input bit clr);
    bit hit;
    m_oos = 0;
    hit = r1 ? (a == (m_want_p1 ? P1 : P0)) : (a == P0 && b == P1);
    if (m_state == 1) begin
      if (hit) begin
        m_good = m_good + 1;
        if (r1) m_want_p1 = !m_want_p1;
      end else if (r1 && (a == P0 || a == P1)) begin
        m_good = 1;
        m_want_p1 = (a == P0);
      end else begin
        m_good = 0;
      end
      if (m_good == LOCK) begin m_state = 2; m_run = 0; end
    end else if (m_state == 2) begin
      if (r1) m_want_p1 = !m_want_p1;
      if (hit) begin m_match++; m_run = 0; end
      else begin m_errc++; m_err = 1; m_run++; end
      if (m_run == LIM) begin m_state = 1; m_good = 0; m_run = 0; m_oos = 1; end
    end
    if (clr) begin m_match = 0; m_errc = 0; m_err = 0; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".locked"}, 64'(locked), 64'(m_state == 2));
    chk({tag, ".oos"},    64'(oos),    64'(m_oos));
    chk({tag, ".err"},    64'(err),    64'(m_err));
    chk({tag, ".match"},  64'(match_cnt), 64'(m_match));
    chk({tag, ".errcnt"}, 64'(err_cnt),   64'(m_errc));
    chk({tag, ".match4"}, 64'(match_cnt4), 64'(sat15(m_match)));
    chk({tag, ".errcnt4"}, 64'(err_cnt4),  64'(sat15(m_errc)));
    chk({tag, ".locked4"}, 64'(locked4),   64'(m_state == 2));
  endtask

  // Entered on a negedge; drives one valid sample and checks 2 clk later.
  task automatic send(input logic [23:0] a, input logic [23:0] b, input bit clr, input string tag);
    adc_valid = 1'b1;
    {adc_data_i1, adc_data_q1} = a;
    {adc_data_i2, adc_data_q2} = b;
    @(negedge clk);
    adc_valid = 1'b0;
    chk_clear = clr;
    @(negedge clk);
    chk_clear = 1'b0;
    m_sample(a, b, adc_r1_mode, clr);
    check_all(tag);
  endtask

  task automatic send_tx(input string tag);
    send(tx_p1 ? P1 : P0, 24'($urandom), 1'b0, tag);
    tx_p1 = !tx_p1;
  endtask

  task automatic mode_change(input bit r1, input string tag);
    adc_r1_mode = r1;
    @(negedge clk);
    if (m_state != 0) begin m_state = 1; m_good = 0; m_run = 0; end
    m_oos = 0;
    check_all(tag);
  endtask

  initial begin
    logic [23:0] w;
    int r;
    rstn = 1'b0; adc_valid = 1'b0; chk_clear = 1'b0; chk_enable = 1'b1; adc_r1_mode = 1'b1;
    adc_data_i1 = '0; adc_data_q1 = '0; adc_data_i2 = '0; adc_data_q2 = '0;
    tx_p1 = 1'b0;
    m_reset();
    #1;
    chk("rst.locked", 64'(locked), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.oos", 64'(oos), 64'd0);
    chk("rst.match", 64'(match_cnt), 64'd0);
    chk("rst.errcnt", 64'(err_cnt), 64'd0);
    #20;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    m_state = 1;
    check_all("enable");
    @(negedge clk);

    // Clean alternating stream: lock after 16, then 24 counted matches
    for (int k = 0; k < 40; k++) send_tx("lock40");
    chk("lock40.final_match", 64'(match_cnt), 64'd24);
    chk("lock40.final_err", 64'(err_cnt), 64'd0);
    chk("lock40.final_sat4", 64'(match_cnt4), 64'hF);

    // Single corrupted I word, next sample must still match
    w = tx_p1 ? P1 : P0;
    w[23:12] = 12'o0000;
    send(w, 24'd0, 1'b0, "corrupt1");
    tx_p1 = !tx_p1;
    send_tx("after_corrupt");
    chk("corrupt1.locked", 64'(locked), 64'd1);

    // Four bad words in a row drop lock, then re-lock
    for (int k = 0; k < 4; k++) begin
      send(24'd0, 24'd0, 1'b0, "bad_run");
      tx_p1 = !tx_p1;
    end
    for (int k = 0; k < 18; k++) send_tx("relock");

    // Clear coincident with a counted good sample
    send(tx_p1 ? P1 : P0, 24'd0, 1'b1, "clear");
    tx_p1 = !tx_p1;
    chk("clear.match_zero", 64'(match_cnt), 64'd0);

    // Randomized stream: mostly correct words, some swapped or garbage, random gaps and clears
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      w = tx_p1 ? P1 : P0;
      else if (r < 90) w = tx_p1 ? P0 : P1;
      else             w = 24'($urandom);
      send(w, 24'($urandom), ($urandom_range(0, 99) < 4), "rand");
      tx_p1 = !tx_p1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Disable forces idle with counters held, re-enable goes back to search
    chk_enable = 1'b0;
    @(negedge clk);
    m_state = 0; m_good = 0; m_run = 0; m_oos = 0;
    check_all("disable");
    chk_enable = 1'b1;
    @(negedge clk);
    m_state = 1;
    check_all("reenable");

    // Two-channel mode: {P0,P1} every sample
    mode_change(1'b0, "to_2r");
    send(P0, 24'd0, 1'b0, "2r_bad");
    for (int k = 0; k < 16; k++) send(P0, P1, 1'b0, "2r");
    chk("2r.locked", 64'(locked), 64'd1);
    mode_change(1'b1, "to_r1");
    chk("to_r1.oos", 64'(oos), 64'd0);
    for (int k = 0; k < 3; k++) send_tx("r1_again");

    // Asynchronous reset in the middle of a sample
    adc_valid = 1'b1;
    {adc_data_i1, adc_data_q1} = P0;
    #2 rstn = 1'b0;
    adc_valid = 1'b0;
    #1;
    chk("midrst.locked", 64'(locked), 64'd0);
    chk("midrst.err", 64'(err), 64'd0);
    chk("midrst.oos", 64'(oos), 64'd0);
    chk("midrst.match", 64'(match_cnt), 64'd0);
    chk("midrst.errcnt", 64'(err_cnt), 64'd0);
    chk("midrst.match4", 64'(match_cnt4), 64'd0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    m_state = 1;
    check_all("post_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
